// File: rtl/regbank_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_scoreboard
//  Brief    : Clocked register bank with one write port, two registered read
//             ports, optional write-to-read bypass and a per-register busy
//             scoreboard for tracking pending writebacks.
//  Revision : 1.0 - initial clocked, parametrised release
// ============================================================================
module regbank_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 16,
    parameter int ZERO_REG   = 0,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] IN_C,
    input  logic [DATA_WIDTH-1:0] E,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] OUT_A,
    input  logic [ADDR_WIDTH-1:0] OUT_B,
    input  logic                  reserve_en,
    input  logic [ADDR_WIDTH-1:0] reserve_addr,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    output logic                  A_busy,
    output logic                  B_busy,
    output logic [NUM_REGS-1:0]   busy_mask
);

    // One extra bit so NUM_REGS == 2**ADDR_WIDTH is still representable.
    localparam logic [ADDR_WIDTH:0] c_NUM_REGS = (ADDR_WIDTH+1)'(NUM_REGS);
    localparam logic                c_ZERO_REG = (ZERO_REG != 0);
    localparam logic                c_BYPASS   = (BYPASS != 0);

    // An address names a real, writable register: inside the implemented
    // range and not the hardwired zero register.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] x);
        return ({1'b0, x} < c_NUM_REGS) && !(c_ZERO_REG && (x == '0));
    endfunction

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_busy;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_a_busy;
    logic                  r_b_busy;

    logic                  w_wr_ok;
    logic                  w_rsv_ok;
    logic                  w_a_ok;
    logic                  w_b_ok;
    logic                  w_a_hit;
    logic                  w_b_hit;
    logic [DATA_WIDTH-1:0] w_reg_a;
    logic [DATA_WIDTH-1:0] w_reg_b;
    logic                  w_busy_a;
    logic                  w_busy_b;
    logic [DATA_WIDTH-1:0] w_val_a;
    logic [DATA_WIDTH-1:0] w_val_b;
    logic                  w_nbusy_a;
    logic                  w_nbusy_b;

    assign w_wr_ok  = enable && addr_ok(IN_C);
    assign w_rsv_ok = reserve_en && addr_ok(reserve_addr);
    assign w_a_ok   = addr_ok(OUT_A);
    assign w_b_ok   = addr_ok(OUT_B);

    // A read port "hits" the write port when a real write targets the same
    // register this cycle; that write both supplies data and clears busy.
    assign w_a_hit  = w_wr_ok && (IN_C == OUT_A);
    assign w_b_hit  = w_wr_ok && (IN_C == OUT_B);

    // Per-register storage and scoreboard bit; reserve beats a same-cycle write.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic w_wr_sel;
            logic w_rsv_sel;
            assign w_wr_sel  = w_wr_ok  && (IN_C == ADDR_WIDTH'(gi));
            assign w_rsv_sel = w_rsv_ok && (reserve_addr == ADDR_WIDTH'(gi));

            // Register contents and busy bit update.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_regs[gi] <= '0;
                    r_busy[gi] <= 1'b0;
                end else begin
                    if (w_wr_sel) begin
                        r_regs[gi] <= E;
                    end
                    if (w_rsv_sel) begin
                        r_busy[gi] <= 1'b1;
                    end else if (w_wr_sel) begin
                        r_busy[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // Pre-edge register contents and busy state for both read addresses.
    always_comb begin
        w_reg_a  = '0;
        w_reg_b  = '0;
        w_busy_a = 1'b0;
        w_busy_b = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (OUT_A == ADDR_WIDTH'(i)) begin
                w_reg_a  = r_regs[i];
                w_busy_a = r_busy[i];
            end
            if (OUT_B == ADDR_WIDTH'(i)) begin
                w_reg_b  = r_regs[i];
                w_busy_b = r_busy[i];
            end
        end
    end

    assign w_val_a   = !w_a_ok ? '0 : (c_BYPASS && w_a_hit) ? E : w_reg_a;
    assign w_val_b   = !w_b_ok ? '0 : (c_BYPASS && w_b_hit) ? E : w_reg_b;
    assign w_nbusy_a = w_a_ok && w_busy_a && !w_a_hit;
    assign w_nbusy_b = w_b_ok && w_busy_b && !w_b_hit;

    // Registered read ports; they hold their value while read_en is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_a_busy <= 1'b0;
            r_b_busy <= 1'b0;
        end else if (read_en) begin
            r_a      <= w_val_a;
            r_b      <= w_val_b;
            r_a_busy <= w_nbusy_a;
            r_b_busy <= w_nbusy_b;
        end
    end

    assign A         = r_a;
    assign B         = r_b;
    assign A_busy    = r_a_busy;
    assign B_busy    = r_b_busy;
    assign busy_mask = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regbank_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regbank_scoreboard
//  Brief    : Scoreboard bench for regbank_scoreboard. Two instances share the
//             stimulus: one with a zero register, bypass and a partial
//             address range, one without zero register or bypass.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regbank_scoreboard;

    localparam int c_NR0 = 14;
    localparam int c_ZR0 = 1;
    localparam int c_BP0 = 1;
    localparam int c_NR1 = 16;
    localparam int c_ZR1 = 0;
    localparam int c_BP1 = 0;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  IN_C = '0;
    logic [31:0] E = '0;
    logic        read_en = 1'b0;
    logic [3:0]  OUT_A = '0;
    logic [3:0]  OUT_B = '0;
    logic        reserve_en = 1'b0;
    logic [3:0]  reserve_addr = '0;

    logic [31:0]      a0, b0, a1, b1;
    logic             ab0, bb0, ab1, bb1;
    logic [c_NR0-1:0] mask0;
    logic [c_NR1-1:0] mask1;

    regbank_scoreboard #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(c_NR0),
        .ZERO_REG(c_ZR0), .BYPASS(c_BP0)
    ) dut0 (
        .clock(clock), .reset(reset), .enable(enable), .IN_C(IN_C), .E(E),
        .read_en(read_en), .OUT_A(OUT_A), .OUT_B(OUT_B),
        .reserve_en(reserve_en), .reserve_addr(reserve_addr),
        .A(a0), .B(b0), .A_busy(ab0), .B_busy(bb0), .busy_mask(mask0)
    );

    regbank_scoreboard #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(c_NR1),
        .ZERO_REG(c_ZR1), .BYPASS(c_BP1)
    ) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .IN_C(IN_C), .E(E),
        .read_en(read_en), .OUT_A(OUT_A), .OUT_B(OUT_B),
        .reserve_en(reserve_en), .reserve_addr(reserve_addr),
        .A(a1), .B(b1), .A_busy(ab1), .B_busy(bb1), .busy_mask(mask1)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ab;
        logic        bb;
        logic [15:0] mask;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state per instance
    logic [31:0] m_regs [2][16];
    logic        m_busy [2][16];
    logic [31:0] m_a [2];
    logic [31:0] m_b [2];
    logic        m_ab [2];
    logic        m_bb [2];

    function automatic int nr(int d);  return (d == 0) ? c_NR0 : c_NR1; endfunction
    function automatic bit zr(int d);  return (d == 0) ? (c_ZR0 != 0) : (c_ZR1 != 0); endfunction
    function automatic bit bp(int d);  return (d == 0) ? (c_BP0 != 0) : (c_BP1 != 0); endfunction

    // A register that exists and can hold a value
    function automatic bit real_reg(int d, int x);
        return (x < nr(d)) && !(zr(d) && x == 0);
    endfunction

    function automatic logic [31:0] read_value(int d, int x, bit wr);
        if (!real_reg(d, x)) return 32'h0;
        if (bp(d) && wr && int'(IN_C) == x) return E;
        return m_regs[d][x];
    endfunction

    function automatic logic read_busy(int d, int x, bit wr);
        if (!real_reg(d, x)) return 1'b0;
        if (wr && int'(IN_C) == x) return 1'b0;
        return m_busy[d][x];
    endfunction

    // Advance the model by one clock edge using the currently driven inputs,
    // then queue the outputs the instance must show after that edge.
    task automatic model_step(int d);
        exp_t ex;
        bit   wr;
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_regs[d][i] = '0;
                m_busy[d][i] = 1'b0;
            end
            m_a[d] = '0; m_b[d] = '0; m_ab[d] = 1'b0; m_bb[d] = 1'b0;
        end else begin
            wr = enable && real_reg(d, int'(IN_C));
            if (read_en) begin
                m_a[d]  = read_value(d, int'(OUT_A), wr);
                m_b[d]  = read_value(d, int'(OUT_B), wr);
                m_ab[d] = read_busy(d, int'(OUT_A), wr);
                m_bb[d] = read_busy(d, int'(OUT_B), wr);
            end
            if (wr) begin
                m_regs[d][IN_C] = E;
                m_busy[d][IN_C] = 1'b0;
            end
            if (reserve_en && real_reg(d, int'(reserve_addr)))
                m_busy[d][reserve_addr] = 1'b1;
        end
        ex.a = m_a[d]; ex.b = m_b[d]; ex.ab = m_ab[d]; ex.bb = m_bb[d];
        ex.mask = '0;
        for (int i = 0; i < nr(d); i++) ex.mask[i] = m_busy[d][i];
        if (d == 0) q0.push_back(ex); else q1.push_back(ex);
    endtask

    // Drive one cycle of stimulus (away from the active edge)
    task automatic cyc(input logic rst, input logic en, input logic [3:0] c,
                       input logic [31:0] e, input logic re,
                       input logic [3:0] oa, input logic [3:0] ob,
                       input logic rsv, input logic [3:0] ra);
        @(negedge clock);
        reset = rst; enable = en; IN_C = c; E = e; read_en = re;
        OUT_A = oa; OUT_B = ob; reserve_en = rsv; reserve_addr = ra;
        model_step(0);
        model_step(1);
    endtask

    task automatic compare(int d, exp_t ex, logic [31:0] a, logic [31:0] b,
                           logic ab, logic bb, logic [15:0] mask);
        bit bad = 0;
        if (a !== ex.a) begin
            $display("FAIL dut%0d A: got %h expected %h at %0t", d, a, ex.a, $time); bad = 1;
        end
        if (b !== ex.b) begin
            $display("FAIL dut%0d B: got %h expected %h at %0t", d, b, ex.b, $time); bad = 1;
        end
        if (ab !== ex.ab) begin
            $display("FAIL dut%0d A_busy: got %b expected %b at %0t", d, ab, ex.ab, $time); bad = 1;
        end
        if (bb !== ex.bb) begin
            $display("FAIL dut%0d B_busy: got %b expected %b at %0t", d, bb, ex.bb, $time); bad = 1;
        end
        if (mask !== ex.mask) begin
            $display("FAIL dut%0d busy_mask: got %h expected %h at %0t", d, mask, ex.mask, $time); bad = 1;
        end
        n_vec++;
        if (bad) n_err++;
    endtask

    // Monitor: after every active edge, pop and compare one entry per instance
    initial begin
        exp_t ex;
        forever begin
            @(posedge clock);
            #1;
            if (q0.size() > 0) begin
                ex = q0.pop_front();
                compare(0, ex, a0, b0, ab0, bb0, {2'b00, mask0});
            end
            if (q1.size() > 0) begin
                ex = q1.pop_front();
                compare(1, ex, a1, b1, ab1, bb1, mask1);
            end
        end
    end

    initial begin
        // Reset after a write to r5, then read r5
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 5, 5, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 5, 5, 0, 0);
        // Basic write then read on both ports
        cyc(0, 1, 3, 32'h12345678, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 3, 3, 0, 0);
        // Bypass: r7=1, then write r7=CAFE while reading r7
        cyc(0, 1, 7, 32'h1, 0, 0, 0, 0, 0);
        cyc(0, 1, 7, 32'hCAFE, 1, 7, 3, 0, 0);
        cyc(0, 0, 0, 0, 1, 7, 7, 0, 0);
        // Scoreboard on r9
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 9);
        cyc(0, 0, 0, 0, 1, 9, 3, 0, 0);
        cyc(0, 1, 9, 32'h55, 1, 9, 9, 0, 0);
        cyc(0, 1, 9, 32'h66, 1, 9, 9, 1, 9);
        cyc(0, 0, 0, 0, 1, 9, 9, 1, 9);
        // Reservation and read of the same register in one cycle
        cyc(0, 0, 0, 0, 1, 4, 4, 1, 4);
        // Zero register: write and reserve r0, then read r0
        cyc(0, 1, 0, 32'hFFFF, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
        // Out-of-range addresses for the 14-register instance
        cyc(0, 1, 15, 32'hA5A5A5A5, 0, 0, 0, 1, 14);
        cyc(0, 0, 0, 0, 1, 15, 14, 0, 0);
        // Hold: read r2, then r2 changes while read_en is low
        cyc(0, 1, 2, 32'h22, 1, 2, 2, 0, 0);
        cyc(0, 0, 0, 0, 1, 2, 2, 0, 0);
        cyc(0, 1, 2, 32'h33, 0, 2, 2, 1, 2);
        cyc(0, 1, 2, 32'h44, 0, 2, 2, 0, 0);
        cyc(0, 1, 2, 32'h55, 0, 2, 2, 0, 0);
        cyc(0, 0, 0, 0, 1, 2, 2, 0, 0);
        // Reset has priority over a same-cycle write and reserve
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 6);
        cyc(1, 1, 4, 32'h4444, 1, 4, 6, 1, 4);
        cyc(0, 0, 0, 0, 1, 4, 6, 0, 0);
        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 1) == 1),
                4'($urandom_range(0, 15)),
                $urandom,
                ($urandom_range(0, 3) != 0),
                4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)),
                ($urandom_range(0, 2) == 0),
                4'($urandom_range(0, 15)));
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clock);
        #2;
        if (q0.size() != 0 || q1.size() != 0 || n_vec < 24) begin
            $display("FAIL drain: %0d/%0d entries left, %0d compared", q0.size(), q1.size(), n_vec);
            n_err++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
